// File: rtl/envelope_gen.sv
// -----------------------------------------------------------------------------
// envelope_gen
//
// ADSR amplitude envelope stage on the codec clock. Each signed 16-bit sample
// is scaled by an unsigned 16-bit envelope level. A key gate drives the level
// through attack, decay, sustain and release phases. The level moves once per
// envelope tick (every TICK_DIV clocks).
//
// Parameters
//   TICK_DIV      clocks per envelope update tick (256 @ 12.288 MHz = 48 kHz)
//
// Ports
//   clk           codec clock, rising edge
//   reset         asynchronous, active-low reset
//   gate          key held (asynchronous to clk, synchronized internally)
//   attack_rate   attack step control   (step = rate << 4)
//   decay_rate    decay step control    (step = rate << 4)
//   sustain       sustain level control (level = {sustain, sustain})
//   release_rate  release step control  (step = rate << 4)
//   sample_in     signed input sample
//   sample_out    signed enveloped sample, one clock of latency
//   level         current envelope level, unsigned
//   state         current phase: IDLE=0 ATTACK=1 DECAY=2 SUSTAIN=3 RELEASE=4
//   active        high whenever state != IDLE
// -----------------------------------------------------------------------------
module envelope_gen #(
    parameter int unsigned TICK_DIV = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        gate,
    input  logic [7:0]  attack_rate,
    input  logic [7:0]  decay_rate,
    input  logic [7:0]  sustain,
    input  logic [7:0]  release_rate,
    input  logic [15:0] sample_in,
    output logic [15:0] sample_out,
    output logic [15:0] level,
    output logic [2:0]  state,
    output logic        active
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_state_t;

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    env_state_t       state_q;
    env_state_t       state_d;
    logic [15:0]      level_d;
    logic             gate_meta;
    logic             gate_s;
    logic [CNT_W-1:0] tick_cnt;
    logic             tick;
    logic [7:0]       rate;
    logic [15:0]      step;
    logic [15:0]      sus;
    logic [16:0]      attack_sum;
    logic [15:0]      level_minus_step;
    logic             step_underflow;
    logic signed [31:0] product;

    // -------------------------------------------------------------------------
    // Gate synchronizer and tick counter
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of the others; blocking here would collapse the two
    // synchronizer stages into one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gate_meta <= 1'b0;
            gate_s    <= 1'b0;
        end else begin
            gate_meta <= gate;
            gate_s    <= gate_meta;
        end
    end

    assign tick = (tick_cnt == CNT_MAX);

    // Explicit wrap so non-power-of-two TICK_DIV values divide correctly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Step arithmetic shared by the phases
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // through the case leaves it unassigned and no latch is inferred.
        rate = 8'd0;
        case (state_q)
            ATTACK:  rate = attack_rate;
            DECAY:   rate = decay_rate;
            RELEASE: rate = release_rate;
            default: rate = 8'd0;
        endcase
    end

    assign step             = {4'b0, rate, 4'b0};
    assign sus              = {sustain, sustain};
    assign attack_sum       = {1'b0, level} + {1'b0, step};
    assign level_minus_step = level - step;
    // A wrapped subtraction is treated as "below sustain / below zero".
    assign step_underflow   = (level < step);

    // -------------------------------------------------------------------------
    // Envelope FSM: next state and next level
    // -------------------------------------------------------------------------
    // Gate-driven transitions are checked before the tick so that a gate edge
    // landing on a tick cycle changes phase without stepping the level.
    always_comb begin
        state_d = state_q;
        level_d = level;
        case (state_q)
            IDLE: begin
                level_d = 16'd0;
                if (gate_s) state_d = ATTACK;
            end
            ATTACK: begin
                if (!gate_s) begin
                    state_d = RELEASE;
                end else if (tick) begin
                    if (rate == 8'd0 || attack_sum >= 17'h0_FFFF) begin
                        level_d = 16'hFFFF;
                        state_d = DECAY;
                    end else begin
                        level_d = attack_sum[15:0];
                    end
                end
            end
            DECAY: begin
                if (!gate_s) begin
                    state_d = RELEASE;
                end else if (tick) begin
                    if (rate == 8'd0 || step_underflow || level_minus_step <= sus) begin
                        level_d = sus;
                        state_d = SUSTAIN;
                    end else begin
                        level_d = level_minus_step;
                    end
                end
            end
            SUSTAIN: begin
                // Track live sustain changes, but freeze the level on the
                // cycle the gate drops so release starts from where we were.
                if (!gate_s) begin
                    state_d = RELEASE;
                end else begin
                    level_d = sus;
                end
            end
            RELEASE: begin
                if (gate_s) begin
                    state_d = ATTACK;
                end else if (tick) begin
                    if (rate == 8'd0 || level <= step) begin
                        level_d = 16'd0;
                        state_d = IDLE;
                    end else begin
                        level_d = level_minus_step;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                level_d = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            level   <= 16'd0;
            active  <= 1'b0;
        end else begin
            state_q <= state_d;
            level   <= level_d;
            active  <= (state_d != IDLE);
        end
    end

    assign state = state_q;

    // -------------------------------------------------------------------------
    // Sample scaling
    // -------------------------------------------------------------------------
    // Level is zero-extended so it is always a non-negative multiplier; the
    // full product fits in 32 signed bits. The arithmetic shift gives a floor.
    assign product = $signed({{16{sample_in[15]}}, sample_in}) * $signed({16'b0, level});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_out <= 16'd0;
        end else begin
            sample_out <= 16'(product >>> 16);
        end
    end

endmodule

// File: tb/tb_envelope_gen.sv
// -----------------------------------------------------------------------------
// tb_envelope_gen
//
// Self-checking bench for envelope_gen with TICK_DIV=4. A behavioural model
// (integer arithmetic on phase/level) runs beside the DUT and every output is
// compared on each falling edge; directed sequences and a multiply table add
// fixed expectations for the corner cases.
// -----------------------------------------------------------------------------
module tb_envelope_gen;

    localparam int TICK_DIV = 4;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        gate  = 1'b0;
    logic [7:0]  attack_rate  = 8'd0;
    logic [7:0]  decay_rate   = 8'd0;
    logic [7:0]  sustain      = 8'd0;
    logic [7:0]  release_rate = 8'd0;
    logic [15:0] sample_in    = 16'd0;
    logic [15:0] sample_out;
    logic [15:0] level;
    logic [2:0]  state;
    logic        active;

    int n_checks = 0;
    int n_errors = 0;

    envelope_gen #(.TICK_DIV(TICK_DIV)) dut (
        .clk          (clk),
        .reset        (reset),
        .gate         (gate),
        .attack_rate  (attack_rate),
        .decay_rate   (decay_rate),
        .sustain      (sustain),
        .release_rate (release_rate),
        .sample_in    (sample_in),
        .sample_out   (sample_out),
        .level        (level),
        .state        (state),
        .active       (active)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    typedef struct {
        int ph;   // 0 idle, 1 attack, 2 decay, 3 sustain, 4 release
        int lvl;
    } env_t;

    function automatic env_t env_next(input env_t cur, input bit gs, input bit tk);
        env_t nx;
        int rate;
        int step;
        int sus;
        nx   = cur;
        sus  = int'(sustain) * 257;
        rate = 0;
        case (cur.ph)
            1: rate = int'(attack_rate);
            2: rate = int'(decay_rate);
            4: rate = int'(release_rate);
            default: rate = 0;
        endcase
        step = rate * 16;
        case (cur.ph)
            0: begin
                nx.lvl = 0;
                if (gs) nx.ph = 1;
            end
            1: begin
                if (!gs) nx.ph = 4;
                else if (tk) begin
                    if (rate == 0 || cur.lvl + step >= 65535) begin
                        nx.lvl = 65535; nx.ph = 2;
                    end else nx.lvl = cur.lvl + step;
                end
            end
            2: begin
                if (!gs) nx.ph = 4;
                else if (tk) begin
                    if (rate == 0 || cur.lvl - step <= sus) begin
                        nx.lvl = sus; nx.ph = 3;
                    end else nx.lvl = cur.lvl - step;
                end
            end
            3: begin
                if (!gs) nx.ph = 4;
                else nx.lvl = sus;
            end
            default: begin
                if (gs) nx.ph = 1;
                else if (tk) begin
                    if (rate == 0 || cur.lvl <= step) begin
                        nx.lvl = 0; nx.ph = 0;
                    end else nx.lvl = cur.lvl - step;
                end
            end
        endcase
        return nx;
    endfunction

    function automatic int mul_floor(input logic [15:0] s, input int l);
        longint p;
        p = longint'($signed(s)) * longint'(l);
        return int'(p >>> 16);
    endfunction

    env_t m_env     = '{0, 0};
    bit   m_hist[2] = '{1'b0, 1'b0};  // gate as seen 1 and 2 clocks ago
    int   m_cycles  = 0;
    int   m_out     = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_env    <= '{0, 0};
            m_hist   <= '{1'b0, 1'b0};
            m_cycles <= 0;
            m_out    <= 0;
        end else begin : model_step
            env_t nx;
            nx = env_next(m_env, m_hist[1], (m_cycles % TICK_DIV) == TICK_DIV - 1);
            m_out    <= mul_floor(sample_in, m_env.lvl);
            m_env    <= nx;
            m_hist   <= '{gate, m_hist[0]};
            m_cycles <= m_cycles + 1;
        end
    end

    always @(negedge clk) begin
        check("bg_state",  {29'b0, state},      m_env.ph);
        check("bg_level",  {16'b0, level},      m_env.lvl);
        check("bg_active", {31'b0, active},     (m_env.ph != 0) ? 1 : 0);
        check("bg_out",    {16'b0, sample_out}, {16'b0, m_out[15:0]});
    end

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    task automatic step_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, input string name);
        int i;
        i = 0;
        while (state !== st && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(name, {29'b0, state}, {29'b0, st});
    endtask

    task automatic wait_leave(input logic [2:0] st, input int budget, input string name);
        int i;
        i = 0;
        while (state === st && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(name, (state !== st) ? 1 : 0, 1);
    endtask

    typedef struct {
        logic [7:0]  sus;
        logic [15:0] smp;
        logic [15:0] exp;
    } mul_vec_t;

    mul_vec_t mul_vecs[6];

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin : main
        int n;
        int prev;
        int expv;
        int i;

        mul_vecs[0] = '{8'hFF, 16'h7FFF, 16'h7FFE};
        mul_vecs[1] = '{8'hFF, 16'h8000, 16'h8000};
        mul_vecs[2] = '{8'h80, 16'h4000, 16'h2020};
        mul_vecs[3] = '{8'h80, 16'hC000, 16'hDFE0};
        mul_vecs[4] = '{8'hFF, 16'h0001, 16'h0000};
        mul_vecs[5] = '{8'hFF, 16'hFFFF, 16'hFFFF};

        // Reset state
        step_n(2);
        check("reset_state",  {29'b0, state},      0);
        check("reset_level",  {16'b0, level},      0);
        check("reset_out",    {16'b0, sample_out}, 0);
        check("reset_active", {31'b0, active},     0);
        reset = 1'b1;
        step_n(3);

        // Reset mid-attack
        attack_rate = 8'h80;
        sample_in   = 16'h7FFF;
        gate        = 1'b1;
        i = 0;
        while (level !== 16'h3000 && i < 100) begin
            @(negedge clk);
            i++;
        end
        check("mid_attack_level", {16'b0, level}, 32'h3000);
        @(posedge clk);
        #2;
        reset = 1'b0;
        gate  = 1'b0;
        #1;
        check("async_reset_state", {29'b0, state},      0);
        check("async_reset_level", {16'b0, level},      0);
        check("async_reset_out",   {16'b0, sample_out}, 0);
        check("async_reset_active", {31'b0, active},    0);
        @(negedge clk);
        reset = 1'b1;
        step_n(8);
        check("idle_after_reset", {29'b0, state}, 0);

        // Attack: step 0x800 from 0, 32 ticks to the top
        attack_rate  = 8'h80;
        decay_rate   = 8'hFF;
        sustain      = 8'h80;
        release_rate = 8'h10;
        sample_in    = 16'h4000;
        gate = 1'b1;
        step_n(2);
        check("gate_latency_idle", {29'b0, state}, 0);
        step_n(1);
        check("gate_latency_attack", {29'b0, state}, 1);
        check("attack_start_level", {16'b0, level}, 0);
        prev = 0; n = 0; i = 0;
        while (state === 3'd1 && i < 200) begin
            @(negedge clk);
            i++;
            if (int'(level) != prev) begin
                n++;
                expv = (prev + 'h800 >= 'hFFFF) ? 'hFFFF : prev + 'h800;
                check("attack_step", {16'b0, level}, expv);
                prev = int'(level);
            end
        end
        check("attack_ticks", n, 32);
        check("attack_top",   {16'b0, level}, 32'hFFFF);
        check("attack_to_decay", {29'b0, state}, 2);

        // Decay: step 0xFF0 toward 0x8080, clamping on the 8th tick
        prev = int'(level); n = 0; i = 0;
        while (state === 3'd2 && i < 100) begin
            @(negedge clk);
            i++;
            if (int'(level) != prev) begin
                n++;
                expv = (prev - 'hFF0 <= 'h8080) ? 'h8080 : prev - 'hFF0;
                check("decay_step", {16'b0, level}, expv);
                prev = int'(level);
            end
        end
        check("decay_ticks",   n, 8);
        check("sustain_level", {16'b0, level}, 32'h8080);
        check("sustain_state", {29'b0, state}, 3);

        sustain = 8'h40;
        step_n(1);
        check("sustain_track_40", {16'b0, level}, 32'h4040);
        sustain = 8'h80;
        step_n(1);
        check("sustain_track_80", {16'b0, level}, 32'h8080);

        // Release: step 0x100 from 0x8080, 129 ticks to idle
        gate = 1'b0;
        step_n(3);
        check("release_state", {29'b0, state}, 4);
        check("release_hold",  {16'b0, level}, 32'h8080);
        prev = int'(level); n = 0; i = 0;
        while (state === 3'd4 && i < 700) begin
            @(negedge clk);
            i++;
            if (int'(level) != prev) begin
                n++;
                if (n == 128) check("release_128", {16'b0, level}, 32'h0080);
                expv = (prev <= 'h100) ? 0 : prev - 'h100;
                check("release_step", {16'b0, level}, expv);
                prev = int'(level);
            end
        end
        check("release_ticks",  n, 129);
        check("release_idle",   {29'b0, state},  0);
        check("release_active", {31'b0, active}, 0);

        // Retrigger from 0x4000 during release
        release_rate = 8'h08;
        gate = 1'b1;
        wait_state(3'd3, 300, "retrig_setup_sustain");
        gate = 1'b0;
        wait_state(3'd4, 10, "retrig_setup_release");
        i = 0;
        while (level !== 16'h4000 && i < 700) begin
            @(negedge clk);
            i++;
        end
        check("retrig_reach", {16'b0, level}, 32'h4000);
        gate = 1'b1;
        step_n(3);
        check("retrig_state", {29'b0, state}, 1);
        check("retrig_level", {16'b0, level}, 32'h4000);
        i = 0;
        while (level === 16'h4000 && i < 8) begin
            @(negedge clk);
            i++;
        end
        check("retrig_continue", {16'b0, level}, 32'h4800);

        // Zero rates
        wait_state(3'd3, 200, "zero_setup_sustain");
        attack_rate = 8'h00; decay_rate = 8'h00; release_rate = 8'h00;
        gate = 1'b0;
        wait_state(3'd0, 12, "zero_release_to_idle");
        sustain = 8'hFF;
        gate = 1'b1;
        wait_state(3'd1, 5, "zero_attack");
        wait_leave(3'd1, TICK_DIV + 1, "zero_attack_one_tick");
        check("zero_decay_state", {29'b0, state}, 2);
        check("zero_decay_level", {16'b0, level}, 32'hFFFF);
        wait_leave(3'd2, TICK_DIV + 1, "zero_decay_one_tick");
        check("zero_sustain_state", {29'b0, state}, 3);
        check("zero_sustain_level", {16'b0, level}, 32'hFFFF);
        gate = 1'b0;
        wait_state(3'd4, 5, "zero_release");
        check("zero_release_hold", {16'b0, level}, 32'hFFFF);
        wait_leave(3'd4, TICK_DIV + 1, "zero_release_one_tick");
        check("zero_release_idle",  {29'b0, state}, 0);
        check("zero_release_level", {16'b0, level}, 0);

        // Multiply table (levels set via sustain tracking)
        gate = 1'b1;
        wait_state(3'd3, 20, "mul_setup_sustain");
        for (int k = 0; k < 6; k++) begin
            sustain   = mul_vecs[k].sus;
            sample_in = mul_vecs[k].smp;
            step_n(2);
            check("mul_vec", {16'b0, sample_out}, {16'b0, mul_vecs[k].exp});
        end
        gate = 1'b0;
        wait_state(3'd0, 20, "mul_setup_idle");
        sample_in = 16'h7FFF;
        step_n(2);
        check("mul_zero_level", {16'b0, sample_out}, 0);

        // Randomized run against the model
        for (int seg = 0; seg < 40; seg++) begin
            attack_rate  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            decay_rate   = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            release_rate = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            sustain      = 8'($urandom);
            gate         = ($urandom_range(0, 3) == 0) ? gate : ~gate;
            n = $urandom_range(1, 120);
            for (int c = 0; c < n; c++) begin
                sample_in = 16'($urandom);
                if ($urandom_range(0, 31) == 0) sustain = 8'($urandom);
                @(negedge clk);
            end
        end

        step_n(1);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
